// File: rtl/snake_key_decoder.sv
// snake_key_decoder: decodes the PS/2 set-2 byte stream for the snake game.
// It produces start and restart pulses. For each player it queues direction
// commands in a small FIFO, and the game tick pops one command per step.
module snake_key_decoder #(
    parameter int         NUM_PLAYERS = 1,
    parameter int         QDEPTH      = 4,
    parameter logic [7:0] KEY_UP0     = 8'h1D,
    parameter logic [7:0] KEY_DOWN0   = 8'h1B,
    parameter logic [7:0] KEY_LEFT0   = 8'h1C,
    parameter logic [7:0] KEY_RIGHT0  = 8'h23,
    parameter logic [7:0] KEY_START   = 8'h29,
    parameter logic [7:0] KEY_RESTART = 8'h59
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic                     iPlay,
    input  logic                     iGameover,
    input  logic                     iKeyValid,
    input  logic [7:0]               iKey,
    input  logic                     iStep,
    output logic                     oLdStart,
    output logic                     oLdRestart,
    output logic [4*NUM_PLAYERS-1:0] oDirection,
    output logic [NUM_PLAYERS-1:0]   oDropped
);

    localparam int         PW       = $clog2(QDEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] EXT_UP    = 8'h75;
    localparam logic [7:0] EXT_DOWN  = 8'h72;
    localparam logic [7:0] EXT_LEFT  = 8'h6B;
    localparam logic [7:0] EXT_RIGHT = 8'h74;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_t;
    parse_t state;

    // Swap up/down and left/right inside the one-hot direction.
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // Map the player-0 plain key codes to a direction (0000 if none matches).
    function automatic logic [3:0] map_plain(input logic [7:0] k);
        if (k == KEY_UP0)    return DIR_UP;
        if (k == KEY_DOWN0)  return DIR_DOWN;
        if (k == KEY_LEFT0)  return DIR_LEFT;
        if (k == KEY_RIGHT0) return DIR_RIGHT;
        return 4'b0000;
    endfunction

    // Map the extended arrow-key codes to a direction (0000 if none matches).
    function automatic logic [3:0] map_ext(input logic [7:0] k);
        if (k == EXT_UP)    return DIR_UP;
        if (k == EXT_DOWN)  return DIR_DOWN;
        if (k == EXT_LEFT)  return DIR_LEFT;
        if (k == EXT_RIGHT) return DIR_RIGHT;
        return 4'b0000;
    endfunction

    // ---- stage p0: decode the byte on its strobe cycle ----
    logic       plain_p0, ext_p0, start_p0, restart_p0, push0_p0, push1_p0;
    logic [3:0] cand0_p0, cand1_p0;

    assign plain_p0   = iKeyValid && (state == ST_IDLE) && (iKey != CODE_EXT) && (iKey != CODE_BRK);
    assign ext_p0     = iKeyValid && (state == ST_EXT) && (iKey != CODE_BRK);
    assign start_p0   = plain_p0 && (iKey == KEY_START) && iStart;
    assign restart_p0 = plain_p0 && (iKey == KEY_RESTART) && iGameover;
    assign cand0_p0   = map_plain(iKey);
    assign cand1_p0   = map_ext(iKey);
    assign push0_p0   = plain_p0 && iPlay && (cand0_p0 != 4'b0000);
    assign push1_p0   = ext_p0 && iPlay && (NUM_PLAYERS == 2) && (cand1_p0 != 4'b0000);

    // ---- stage p1: registered parser state and pulses ----
    // The prefix parser advances only on byte strobes; the pulses are registered.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= ST_IDLE;
            oLdStart   <= 1'b0;
            oLdRestart <= 1'b0;
        end else begin
            oLdStart   <= start_p0;
            oLdRestart <= restart_p0;
            if (iKeyValid) begin
                case (state)
                    ST_IDLE: begin
                        if (iKey == CODE_EXT)      state <= ST_EXT;
                        else if (iKey == CODE_BRK) state <= ST_BRK;
                        else                       state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (iKey == CODE_BRK) state <= ST_EXT_BRK;
                        else                  state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]    mem [QDEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [PW:0]   count;
        logic [3:0]    dir_p1;
        logic          drop_p1;

        logic          req_p0, redundant_p0, full_p0, push_p0, pop_p0, drop_p0;
        logic [3:0]    cand_p0, last_p0, ref_p0;

        // The reference is the newest queued entry, or the live direction when the queue is empty.
        assign req_p0       = (p == 0) ? push0_p0 : push1_p0;
        assign cand_p0      = (p == 0) ? cand0_p0 : cand1_p0;
        assign last_p0      = mem[wr_ptr - 1'b1];
        assign ref_p0       = (count != '0) ? last_p0 : dir_p1;
        assign redundant_p0 = (ref_p0 != 4'b0000) &&
                              ((cand_p0 == ref_p0) || (cand_p0 == opposite(ref_p0)));
        assign full_p0      = (count == FULL_CNT);
        assign push_p0      = req_p0 && !redundant_p0 && !full_p0;
        assign drop_p0      = req_p0 && !redundant_p0 && full_p0;
        assign pop_p0       = iStep && (count != '0);

        // FIFO storage; it needs no reset because the count gates every read.
        always_ff @(posedge iClock) begin
            if (push_p0) mem[wr_ptr] <= cand_p0;
        end

        // ---- stage p1: queue control and registered direction/drop outputs ----
        // On restart the queue and direction are cleared, and while not playing the queue is flushed.
        always_ff @(posedge iClock) begin
            if (iReset) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                dir_p1  <= 4'b0000;
                drop_p1 <= 1'b0;
            end else begin
                drop_p1 <= 1'b0;
                if (restart_p0) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    dir_p1 <= 4'b0000;
                end else if (!iPlay) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else begin
                    drop_p1 <= drop_p0;
                    if (push_p0) wr_ptr <= wr_ptr + 1'b1;
                    if (pop_p0) begin
                        dir_p1 <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    case ({push_p0, pop_p0})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            end
        end

        assign oDirection[4*p +: 4] = dir_p1;
        assign oDropped[p]          = drop_p1;
    end

endmodule
